// File: rtl/lsu_scheduler_pkg.sv
// Shared encodings for the load/store scheduler: instruction codes, FSM states,
// memory access sizes and the queued request record.
package lsu_scheduler_pkg;

    localparam logic [5:0] INSN_LB  = 6'd1;
    localparam logic [5:0] INSN_LBU = 6'd2;
    localparam logic [5:0] INSN_LH  = 6'd3;
    localparam logic [5:0] INSN_LHU = 6'd4;
    localparam logic [5:0] INSN_LW  = 6'd5;
    localparam logic [5:0] INSN_SB  = 6'd6;
    localparam logic [5:0] INSN_SH  = 6'd7;
    localparam logic [5:0] INSN_SW  = 6'd8;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        sext;
        logic [4:0]  dst;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Store data is replicated here so the bus sees it on every byte lane.
    function automatic lsu_req_t decode_req(input logic [5:0] meaning, input logic [31:0] addr,
                                            input logic [31:0] wdata, input logic [4:0] dst);
        lsu_req_t r;
        r.wr    = 1'b0;
        r.size  = MEM_SIZE_W;
        r.sext  = 1'b0;
        r.dst   = dst;
        r.addr  = addr;
        r.wdata = wdata;
        case (meaning)
            INSN_LB:  begin r.size = MEM_SIZE_B; r.sext = 1'b1; end
            INSN_LBU: r.size = MEM_SIZE_B;
            INSN_LH:  begin r.size = MEM_SIZE_H; r.sext = 1'b1; end
            INSN_LHU: r.size = MEM_SIZE_H;
            INSN_SB:  begin r.wr = 1'b1; r.size = MEM_SIZE_B; r.wdata = {4{wdata[7:0]}}; end
            INSN_SH:  begin r.wr = 1'b1; r.size = MEM_SIZE_H; r.wdata = {2{wdata[15:0]}}; end
            INSN_SW:  r.wr = 1'b1;
            default:  ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic sext, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(rdata >> {lo, 3'b000});
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_SIZE_B: res = {{24{sext & b[7]}}, b};
            MEM_SIZE_H: res = {{16{sext & h[15]}}, h};
            default:    res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_scheduler_if.sv
// Lane issue, memory bus and writeback signals of the load/store scheduler.
interface lsu_scheduler_if;
    logic        lane0_valid,   lane1_valid;
    logic [5:0]  lane0_meaning, lane1_meaning;
    logic [31:0] lane0_addr,    lane1_addr;
    logic [31:0] lane0_wdata,   lane1_wdata;
    logic [4:0]  lane0_dst,     lane1_dst;
    logic [1:0]  lane_ready;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;

    modport slave (
        input  lane0_valid, lane1_valid, lane0_meaning, lane1_meaning, lane0_addr, lane1_addr,
               lane0_wdata, lane1_wdata, lane0_dst, lane1_dst, mem_addr_ok, mem_data_ok, mem_rdata,
        output lane_ready, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, wb_valid, wb_dst, wb_data
    );

    modport master (
        output lane0_valid, lane1_valid, lane0_meaning, lane1_meaning, lane0_addr, lane1_addr,
               lane0_wdata, lane1_wdata, lane0_dst, lane1_dst, mem_addr_ok, mem_data_ok, mem_rdata,
        input  lane_ready, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, wb_valid, wb_dst, wb_data
    );
endinterface

// File: rtl/lsu_fifo.sv
// Request queue with two in-order push ports and one pop port; free_o already
// credits an entry that is popped in the same cycle.
module lsu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         flush_i,
    input  logic                         push0_i,
    input  logic                         push1_i,
    input  logic [WIDTH-1:0]             data0_i,
    input  logic [WIDTH-1:0]             data1_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   free_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_slot1;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    assign empty_o  = (count_q == '0);
    assign do_pop   = pop_i && !empty_o;
    assign head_o   = mem_q[rd_ptr_q];
    assign free_o   = CW'(DEPTH) - count_q + CW'(do_pop);
    assign wr_slot1 = push0_i ? wr_ptr_q + PW'(1) : wr_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (push0_i) mem_q[wr_ptr_q] <= data0_i;
            if (push1_i) mem_q[wr_slot1] <= data1_i;
        end
    end

endmodule

// File: rtl/lsu_scheduler.sv
// Two-lane load/store scheduler: queues requests in program order and issues
// them one at a time to a split address/data memory handshake.
//
//   state   | meaning
//   IDLE    | no request outstanding, waiting for a queued entry
//   REQ     | mem_req asserted, waiting for mem_addr_ok
//   WAIT    | address accepted, waiting for mem_data_ok
module lsu_scheduler
    import lsu_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            flush,
    lsu_scheduler_if.slave  bus
);
    localparam int CW = $clog2(DEPTH+1);

    lsu_req_t      req0, req1, head;
    logic [CW-1:0] free;
    logic [1:0]    lane_ready;
    logic          push0, push1, pop, empty;

    lsu_state_e    state_q;
    logic          kill_q;
    logic          mem_req_q, mem_wr_q, sext_q;
    logic [1:0]    mem_size_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic [4:0]    dst_q;
    logic          wb_valid_q;
    logic [4:0]    wb_dst_q;
    logic [31:0]   wb_data_q;
    logic          wb_ok;

    assign req0 = decode_req(bus.lane0_meaning, bus.lane0_addr, bus.lane0_wdata, bus.lane0_dst);
    assign req1 = decode_req(bus.lane1_meaning, bus.lane1_addr, bus.lane1_wdata, bus.lane1_dst);

    assign lane_ready[0] = !flush && (free >= CW'(1));
    assign lane_ready[1] = !flush && ((free >= CW'(2)) || ((free >= CW'(1)) && !bus.lane0_valid));
    assign push0 = bus.lane0_valid && lane_ready[0];
    assign push1 = bus.lane1_valid && lane_ready[1];
    assign pop   = (state_q == ST_REQ) && bus.mem_addr_ok;

    lsu_fifo #(.DEPTH(DEPTH), .WIDTH($bits(lsu_req_t))) u_fifo (
        .clk     (clk),
        .rst_    (rst_),
        .flush_i (flush),
        .push0_i (push0),
        .push1_i (push1),
        .data0_i (req0),
        .data1_i (req1),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .free_o  (free)
    );

    // A flush arriving in the completion cycle itself also suppresses writeback.
    assign wb_ok = !mem_wr_q && !kill_q && !flush;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            kill_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= MEM_SIZE_B;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            sext_q      <= 1'b0;
            dst_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_dst_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!empty && !flush) begin
                        state_q     <= ST_REQ;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= head.wr;
                        mem_size_q  <= head.size;
                        mem_addr_q  <= head.addr;
                        mem_wdata_q <= head.wdata;
                        sext_q      <= head.sext;
                        dst_q       <= head.dst;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_addr_ok && bus.mem_data_ok) begin
                        mem_req_q  <= 1'b0;
                        state_q    <= ST_IDLE;
                        kill_q     <= 1'b0;
                        wb_valid_q <= wb_ok;
                        wb_dst_q   <= dst_q;
                        wb_data_q  <= load_extract(bus.mem_rdata, mem_size_q, sext_q, mem_addr_q[1:0]);
                    end else if (bus.mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_WAIT;
                        kill_q    <= kill_q | flush;
                    end else begin
                        kill_q <= kill_q | flush;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_data_ok) begin
                        state_q    <= ST_IDLE;
                        kill_q     <= 1'b0;
                        wb_valid_q <= wb_ok;
                        wb_dst_q   <= dst_q;
                        wb_data_q  <= load_extract(bus.mem_rdata, mem_size_q, sext_q, mem_addr_q[1:0]);
                    end else begin
                        kill_q <= kill_q | flush;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.lane_ready = lane_ready;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_size   = mem_size_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_dst     = wb_dst_q;
    assign bus.wb_data    = wb_data_q;

endmodule

// File: tb/tb_lsu_scheduler.sv
// Directed bench for lsu_scheduler: lane acceptance, issue order, load extension,
// store replication, flush and asynchronous reset behaviour.
module tb_lsu_scheduler;
    import lsu_scheduler_pkg::*;

    logic clk   = 1'b0;
    logic rst_  = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad   = 0;

    lsu_scheduler_if bus();

    lsu_scheduler #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present both lanes for one cycle starting at a falling edge.
    task automatic lanes(input logic v0, input logic [5:0] m0, input logic [31:0] a0,
                         input logic [31:0] w0, input logic [4:0] d0,
                         input logic v1, input logic [5:0] m1, input logic [31:0] a1,
                         input logic [31:0] w1, input logic [4:0] d1, output logic [1:0] rdy);
        bus.lane0_valid = v0; bus.lane0_meaning = m0; bus.lane0_addr = a0;
        bus.lane0_wdata = w0; bus.lane0_dst = d0;
        bus.lane1_valid = v1; bus.lane1_meaning = m1; bus.lane1_addr = a1;
        bus.lane1_wdata = w1; bus.lane1_dst = d1;
        #1 rdy = bus.lane_ready;
        @(negedge clk);
        bus.lane0_valid = 1'b0;
        bus.lane1_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !bus.mem_req; i++) @(negedge clk);
        if (!bus.mem_req) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic serve(input string tag, input logic exp_wr, input logic [1:0] exp_size,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [31:0] rdata, input int delay, input bit same,
                         input logic exp_wb, input logic [4:0] exp_dst, input logic [31:0] exp_data);
        wait_req(tag);
        chk({tag, ".wr"},   bus.mem_wr,   exp_wr);
        chk({tag, ".size"}, bus.mem_size, exp_size);
        chk({tag, ".addr"}, bus.mem_addr, exp_addr);
        if (exp_wr) chk({tag, ".wdata"}, bus.mem_wdata, exp_wdata);
        repeat (delay) begin
            @(negedge clk);
            chk({tag, ".hold_req"},  bus.mem_req,  1'b1);
            chk({tag, ".hold_addr"}, bus.mem_addr, exp_addr);
        end
        bus.mem_addr_ok = 1'b1;
        if (same) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = rdata;
        end
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        chk({tag, ".req_drop"}, bus.mem_req, 1'b0);
        if (!same) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = rdata;
            @(negedge clk);
        end
        bus.mem_data_ok = 1'b0;
        chk({tag, ".wb_valid"}, bus.wb_valid, exp_wb);
        if (exp_wb) begin
            chk({tag, ".wb_dst"},  bus.wb_dst,  exp_dst);
            chk({tag, ".wb_data"}, bus.wb_data, exp_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rdy;
        bus.lane0_valid = 0; bus.lane0_meaning = 0; bus.lane0_addr = 0; bus.lane0_wdata = 0; bus.lane0_dst = 0;
        bus.lane1_valid = 0; bus.lane1_meaning = 0; bus.lane1_addr = 0; bus.lane1_wdata = 0; bus.lane1_dst = 0;
        bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;

        #3;
        chk("rst.mem_req",    bus.mem_req,    1'b0);
        chk("rst.wb_valid",   bus.wb_valid,   1'b0);
        chk("rst.wb_data",    bus.wb_data,    32'h0);
        chk("rst.lane_ready", bus.lane_ready, 2'b11);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);

        // Both lanes on an empty queue: LW issues before SW, only the load writes back.
        lanes(1, INSN_LW, 32'h100, 32'h0, 5'd3, 1, INSN_SW, 32'h104, 32'hDEADBEEF, 5'd0, rdy);
        chk("s1.ready", rdy, 2'b11);
        serve("s1.lw", 0, MEM_SIZE_W, 32'h100, 32'h0, 32'hCAFEF00D, 0, 0, 1, 5'd3, 32'hCAFEF00D);
        serve("s1.sw", 1, MEM_SIZE_W, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 0, 5'd0, 32'h0);

        // Byte and half loads with sign/zero extension.
        lanes(1, INSN_LB, 32'h1003, 32'h0, 5'd4, 1, INSN_LBU, 32'h1003, 32'h0, 5'd5, rdy);
        chk("s2.ready", rdy, 2'b11);
        serve("s2.lb",  0, MEM_SIZE_B, 32'h1003, 32'h0, 32'h80123456, 0, 0, 1, 5'd4, 32'hFFFFFF80);
        serve("s2.lbu", 0, MEM_SIZE_B, 32'h1003, 32'h0, 32'h80123456, 0, 0, 1, 5'd5, 32'h00000080);
        lanes(1, INSN_LH, 32'h2002, 32'h0, 5'd6, 1, INSN_LHU, 32'h2000, 32'h0, 5'd7, rdy);
        serve("s2.lh",  0, MEM_SIZE_H, 32'h2002, 32'h0, 32'h8001BEEF, 0, 0, 1, 5'd6, 32'hFFFF8001);
        serve("s2.lhu", 0, MEM_SIZE_H, 32'h2000, 32'h0, 32'h1234F00F, 0, 1, 1, 5'd7, 32'h0000F00F);

        // Store data replication.
        lanes(1, INSN_SH, 32'h2002, 32'h1234ABCD, 5'd0, 1, INSN_SB, 32'h2001, 32'h000000EF, 5'd0, rdy);
        serve("s5.sh", 1, MEM_SIZE_H, 32'h2002, 32'hABCDABCD, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        serve("s5.sb", 1, MEM_SIZE_B, 32'h2001, 32'hEFEFEFEF, 32'h0, 0, 0, 0, 5'd0, 32'h0);

        // Queue at DEPTH-1, then push and pop together while full.
        lanes(1, INSN_LW, 32'h300, 32'h0, 5'd1, 1, INSN_LW, 32'h304, 32'h0, 5'd2, rdy);
        chk("s3.ready_empty", rdy, 2'b11);
        lanes(1, INSN_LW, 32'h308, 32'h0, 5'd3, 0, INSN_LW, 32'h0, 32'h0, 5'd0, rdy);
        chk("s3.ready_two", rdy, 2'b11);
        lanes(1, INSN_LW, 32'h30C, 32'h0, 5'd4, 1, INSN_LW, 32'h310, 32'h0, 5'd5, rdy);
        chk("s3.ready_one", rdy, 2'b01);
        chk("s3.head_req",  bus.mem_req,  1'b1);
        chk("s3.head_addr", bus.mem_addr, 32'h300);
        bus.mem_addr_ok = 1'b1;
        lanes(1, INSN_LW, 32'h310, 32'h0, 5'd5, 0, INSN_LW, 32'h0, 32'h0, 5'd0, rdy);
        chk("s3.ready_pushpop", rdy, 2'b01);
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h11111111;
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        chk("s3.e1.wb_valid", bus.wb_valid, 1'b1);
        chk("s3.e1.wb_dst",   bus.wb_dst,   5'd1);
        chk("s3.e1.wb_data",  bus.wb_data,  32'h11111111);
        serve("s3.e2", 0, MEM_SIZE_W, 32'h304, 32'h0, 32'h22222222, 0, 0, 1, 5'd2, 32'h22222222);
        serve("s3.e3", 0, MEM_SIZE_W, 32'h308, 32'h0, 32'h33333333, 0, 0, 1, 5'd3, 32'h33333333);
        serve("s3.e4", 0, MEM_SIZE_W, 32'h30C, 32'h0, 32'h44444444, 0, 0, 1, 5'd4, 32'h44444444);
        serve("s3.e5", 0, MEM_SIZE_W, 32'h310, 32'h0, 32'h55555555, 0, 0, 1, 5'd5, 32'h55555555);

        // Flush while WAIT after a withheld address phase.
        lanes(1, INSN_LW, 32'h400, 32'h0, 5'd7, 1, INSN_LW, 32'h404, 32'h0, 5'd8, rdy);
        lanes(1, INSN_LW, 32'h408, 32'h0, 5'd9, 1, INSN_LW, 32'h40C, 32'h0, 5'd10, rdy);
        chk("s4.ready", rdy, 2'b11);
        wait_req("s4");
        repeat (3) begin
            @(negedge clk);
            chk("s4.hold_req",  bus.mem_req,  1'b1);
            chk("s4.hold_addr", bus.mem_addr, 32'h400);
        end
        bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        flush = 1'b1;
        bus.lane0_valid = 1'b1; bus.lane0_meaning = INSN_LW; bus.lane0_addr = 32'h480; bus.lane0_dst = 5'd20;
        bus.lane1_valid = 1'b1; bus.lane1_meaning = INSN_LW; bus.lane1_addr = 32'h484; bus.lane1_dst = 5'd21;
        #1;
        chk("s4.flush_ready", bus.lane_ready, 2'b00);
        chk("s4.req_drop",    bus.mem_req,    1'b0);
        @(negedge clk);
        flush = 1'b0;
        lanes(1, INSN_LW, 32'h500, 32'h0, 5'd11, 1, INSN_LW, 32'h504, 32'h0, 5'd12, rdy);
        chk("s4.post_flush_ready", rdy, 2'b11);
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h66666666;
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        chk("s4.killed_wb",  bus.wb_valid, 1'b0);
        chk("s4.idle_req",   bus.mem_req,  1'b0);
        serve("s4.f", 0, MEM_SIZE_W, 32'h500, 32'h0, 32'h77777777, 0, 0, 1, 5'd11, 32'h77777777);
        serve("s4.g", 0, MEM_SIZE_W, 32'h504, 32'h0, 32'h88888888, 0, 0, 1, 5'd12, 32'h88888888);

        // Asynchronous reset in REQ.
        lanes(1, INSN_LW, 32'h600, 32'h0, 5'd13, 0, INSN_LW, 32'h0, 32'h0, 5'd0, rdy);
        wait_req("s6");
        chk("s6.req_before", bus.mem_req, 1'b1);
        #2 rst_ = 1'b0;
        #1;
        chk("s6.req_async", bus.mem_req,  1'b0);
        chk("s6.wb_async",  bus.wb_valid, 1'b0);
        @(negedge clk);
        rst_ = 1'b1;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h99999999;
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        repeat (3) begin
            chk("s6.no_wb",  bus.wb_valid, 1'b0);
            chk("s6.no_req", bus.mem_req,  1'b0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
